// File: rtl/fp32_rx_operand_assembler.sv
// fp32_rx_operand_assembler: UART 8N1 receiver that assembles 12-byte frames into three 32-bit operands
module fp32_rx_operand_assembler #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        CLK_I,
  input  logic        RSTL_I,
  input  logic        RX_I,
  output logic [31:0] alpha,
  output logic [31:0] bravo,
  output logic [31:0] acc,
  output logic        OPS_VALID_O,
  output logic [7:0]  RX_BYTE_O,
  output logic        RX_BYTE_VALID_O,
  output logic [3:0]  BYTE_CNT_O,
  output logic        FRAME_ERR_O,
  output logic        TIMEOUT_O
);
  localparam int IDLE_LIM = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(IDLE_LIM + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic s1, s2, s3;
  logic [CW-1:0] clk_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic [95:0] stage;
  logic [IW-1:0] idle_cnt;
  logic tick, half, accept, ferr, tmo;
  assign tick = clk_cnt == CW'(CLKS_PER_BIT - 1);
  assign half = clk_cnt == CW'(CLKS_PER_BIT / 2 - 1);
  // two-flop synchronizer plus a history flop for falling-edge detection
  always_ff @(posedge CLK_I or negedge RSTL_I)
    if (!RSTL_I) {s3, s2, s1} <= 3'b111;
    else {s3, s2, s1} <= {s2, s1, RX_I};
  // receiver state register
  always_ff @(posedge CLK_I or negedge RSTL_I)
    if (!RSTL_I) state <= IDLE;
    else state <= state_n;
  // next state and per-cycle byte/error/timeout strobes
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = (s3 && !s2) ? START : IDLE;
      START: state_n = half ? (s2 ? IDLE : DATA) : START;
      DATA:  state_n = (tick && bit_idx == 3'd7) ? STOP : DATA;
      STOP:  state_n = tick ? IDLE : STOP;
    endcase
    accept = state == STOP && tick && s2;
    ferr   = state == STOP && tick && !s2;
    tmo    = state == IDLE && BYTE_CNT_O != 4'd0 && idle_cnt == IW'(IDLE_LIM - 1);
  end
  // bit timing counter and LSB-first data shifter
  always_ff @(posedge CLK_I or negedge RSTL_I)
    if (!RSTL_I) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      clk_cnt <= (state == IDLE || state != state_n || (state == DATA && tick)) ? '0 : clk_cnt + CW'(1);
      bit_idx <= (state == DATA) ? (tick ? bit_idx + 3'd1 : bit_idx) : 3'd0;
      if (state == DATA && tick) shift <= {s2, shift[7:1]};
    end
  // frame staging, operand update, idle timeout and status pulses
  always_ff @(posedge CLK_I or negedge RSTL_I)
    if (!RSTL_I) begin
      alpha           <= '0;
      bravo           <= '0;
      acc             <= '0;
      stage           <= '0;
      idle_cnt        <= '0;
      OPS_VALID_O     <= 1'b0;
      RX_BYTE_O       <= '0;
      RX_BYTE_VALID_O <= 1'b0;
      BYTE_CNT_O      <= '0;
      FRAME_ERR_O     <= 1'b0;
      TIMEOUT_O       <= 1'b0;
    end else begin
      RX_BYTE_VALID_O <= accept;
      FRAME_ERR_O     <= ferr;
      TIMEOUT_O       <= tmo;
      if (accept) begin
        RX_BYTE_O <= shift;
        stage     <= {stage[87:0], shift};
        idle_cnt  <= '0;
        if (BYTE_CNT_O == 4'd11) begin
          {alpha, bravo, acc} <= {stage[87:0], shift};
          BYTE_CNT_O  <= 4'd0;
          OPS_VALID_O <= 1'b1;
        end else begin
          BYTE_CNT_O <= BYTE_CNT_O + 4'd1;
          if (BYTE_CNT_O == 4'd0) OPS_VALID_O <= 1'b0;
        end
      end else if (ferr || tmo) begin
        BYTE_CNT_O <= 4'd0;
        stage      <= '0;
        idle_cnt   <= '0;
      end else if (BYTE_CNT_O == 4'd0) idle_cnt <= '0;
      else if (state == IDLE) idle_cnt <= idle_cnt + IW'(1);
    end
endmodule

// File: tb/tb_fp32_rx_operand_assembler.sv
// tb_fp32_rx_operand_assembler: directed frame, false-start, framing-error, timeout and reset vectors
module tb_fp32_rx_operand_assembler;
  localparam int CPB = 16;
  logic clk = 0, rst_n = 0, rx = 1;
  logic [31:0] alpha, bravo, acc;
  logic ops_valid, byte_valid, frame_err, timeout;
  logic [7:0] rx_byte;
  logic [3:0] byte_cnt;
  int total = 0, bad = 0;
  int vcount = 0, ferr_cnt = 0, tmo_cnt = 0, rise_cnt = 0, fall_cnt = 0, bad_rise = 0, bad_fall = 0;
  logic prev_ops = 0;

  fp32_rx_operand_assembler #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
    .CLK_I(clk), .RSTL_I(rst_n), .RX_I(rx),
    .alpha(alpha), .bravo(bravo), .acc(acc), .OPS_VALID_O(ops_valid),
    .RX_BYTE_O(rx_byte), .RX_BYTE_VALID_O(byte_valid), .BYTE_CNT_O(byte_cnt),
    .FRAME_ERR_O(frame_err), .TIMEOUT_O(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    vcount   += int'(byte_valid);
    ferr_cnt += int'(frame_err);
    tmo_cnt  += int'(timeout);
    if (rst_n && ops_valid && !prev_ops) begin
      rise_cnt++;
      if (!byte_valid || byte_cnt != 4'd0) bad_rise++;
    end
    if (rst_n && !ops_valid && prev_ops) begin
      fall_cnt++;
      if (!byte_valid || byte_cnt != 4'd1) bad_fall++;
    end
    prev_ops = ops_valid;
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    rx = 1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic send_bytes(input logic [95:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(f[95 - 8*i -: 8]);
  endtask

  logic [95:0] f1 = 96'hBF000000_3F400000_00000000;
  logic [95:0] f2 = 96'h3F000000_3EE00000_00000000;
  logic [95:0] f3 = 96'h12345678_9ABCDEF0_0F1E2D3C;
  logic [95:0] f4 = 96'hC0490FDB_402DF854_A5A5005A;
  int v0, seen;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ops", {alpha, bravo, acc}, 96'h0);
    chk("rst_valid", {95'h0, ops_valid}, 96'h0);
    chk("rst_cnt", {92'h0, byte_cnt}, 96'h0);
    chk("rst_byte", {88'h0, rx_byte}, 96'h0);
    rst_n = 1;
    repeat (4) @(posedge clk);

    send_bytes(f1, 0, 11);
    chk("f1_ops", {alpha, bravo, acc}, f1);
    chk("f1_valid", {95'h0, ops_valid}, 96'h1);
    chk("f1_cnt", {92'h0, byte_cnt}, 96'h0);
    chk("f1_pulses", 96'(vcount), 96'd12);
    chk("f1_rise", 96'(rise_cnt), 96'd1);
    chk("f1_lastbyte", {88'h0, rx_byte}, 96'h00);

    send_bytes(f2, 0, 0);
    chk("f2b1_valid", {95'h0, ops_valid}, 96'h0);
    chk("f2b1_ops", {alpha, bravo, acc}, f1);
    chk("f2b1_byte", {88'h0, rx_byte}, 96'h3F);
    send_bytes(f2, 1, 10);
    chk("f2b11_ops", {alpha, bravo, acc}, f1);
    chk("f2b11_cnt", {92'h0, byte_cnt}, 96'd11);
    send_bytes(f2, 11, 11);
    chk("f2_ops", {alpha, bravo, acc}, f2);
    chk("f2_valid", {95'h0, ops_valid}, 96'h1);
    chk("f2_rise_fall", {32'(rise_cnt), 32'(fall_cnt), 32'(bad_fall)}, {32'd2, 32'd1, 32'd0});

    send_bytes(f3, 0, 1);
    v0 = vcount;
    rx = 0;
    repeat (4) @(posedge clk);
    rx = 1;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    chk("fs_novalid", 96'(vcount - v0), 96'd0);
    chk("fs_noerr", 96'(ferr_cnt), 96'd0);
    chk("fs_cnt", {92'h0, byte_cnt}, 96'd2);

    send_bytes(f3, 2, 2);
    send_byte(8'h55, 1'b0);
    chk("fe_pulse", 96'(ferr_cnt), 96'd1);
    chk("fe_cnt", {92'h0, byte_cnt}, 96'd0);
    chk("fe_ops", {alpha, bravo, acc}, f2);
    chk("fe_lastbyte", {88'h0, rx_byte}, 96'h56);

    send_bytes(f3, 0, 4);
    chk("to_cnt5", {92'h0, byte_cnt}, 96'd5);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (timeout) seen = 1;
    end
    chk("to_seen", 96'(seen), 96'd1);
    repeat (10) @(negedge clk);
    chk("to_pulse", 96'(tmo_cnt), 96'd1);
    chk("to_cnt", {92'h0, byte_cnt}, 96'd0);
    chk("to_ops", {alpha, bravo, acc}, f2);
    send_bytes(f3, 0, 11);
    chk("f3_ops", {alpha, bravo, acc}, f3);
    chk("f3_valid", {95'h0, ops_valid}, 96'h1);

    send_bytes(f4, 0, 5);
    rx = 0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = f4[95 - 48 - i];
      repeat (CPB) @(posedge clk);
    end
    #2 rst_n = 0;
    #1;
    chk("mr_ops", {alpha, bravo, acc}, 96'h0);
    chk("mr_misc", {80'h0, ops_valid, byte_valid, frame_err, timeout, byte_cnt, rx_byte},
        96'h0);
    rx = 1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    repeat (4) @(posedge clk);
    send_bytes(f4, 0, 11);
    chk("f4_ops", {alpha, bravo, acc}, f4);
    chk("f4_valid", {95'h0, ops_valid}, 96'h1);
    chk("rise_total", {32'(rise_cnt), 32'(bad_rise), 32'(tmo_cnt)}, {32'd4, 32'd0, 32'd1});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
